// File: rtl/tse_init_seq.sv
// rtl/tse_init_seq.sv - Avalon-MM power-up configuration sequencer for two TSE MACs.
// Each transfer is followed by one idle turnaround cycle, except for back-to-back reset polls.
module tse_init_seq #(
  parameter logic [47:0] MAC_ADDR_0 = 48'h001C_2317_4ACB,
  parameter logic [47:0] MAC_ADDR_1 = 48'h001C_2317_4ACC,
  parameter int unsigned MAX_FRAME  = 1518,
  parameter int unsigned POLL_LIMIT = 1024,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  output logic        avm_mac_sel,
  output logic [7:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        err_mac
);

  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] POLL_MAX = CW'(POLL_LIMIT);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR_RST  = 4'd1;
  localparam logic [3:0] S_RD_POLL = 4'd2;
  localparam logic [3:0] S_WR_MAC0 = 4'd3;
  localparam logic [3:0] S_WR_MAC1 = 4'd4;
  localparam logic [3:0] S_WR_FRM  = 4'd5;
  localparam logic [3:0] S_WR_ENA  = 4'd6;
  localparam logic [3:0] S_NEXT    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;
  localparam logic [3:0] S_ERR     = 4'd9;

  logic [3:0]    state;
  logic          gap;
  logic          first;
  logic [CW-1:0] poll_cnt;
  logic [47:0]   addr_sel;
  logic          bus_state;
  logic          rd_state;
  logic          xfer_ok;
  logic          go;
  logic          unused_rd;

  assign addr_sel  = avm_mac_sel ? MAC_ADDR_1 : MAC_ADDR_0;
  assign unused_rd = ^{avm_readdata[31:14], avm_readdata[12:0]};

  always_comb begin
    avm_address   = 8'h00;
    avm_writedata = 32'h0;
    bus_state     = 1'b0;
    rd_state      = 1'b0;
    case (state)
      S_WR_RST: begin
        avm_address   = 8'h02;
        avm_writedata = 32'h0000_2010;
        bus_state     = 1'b1;
      end
      S_RD_POLL: begin
        avm_address = 8'h02;
        bus_state   = 1'b1;
        rd_state    = 1'b1;
      end
      S_WR_MAC0: begin
        avm_address   = 8'h03;
        avm_writedata = {addr_sel[23:16], addr_sel[31:24], addr_sel[39:32], addr_sel[47:40]};
        bus_state     = 1'b1;
      end
      S_WR_MAC1: begin
        avm_address   = 8'h04;
        avm_writedata = {16'h0, addr_sel[7:0], addr_sel[15:8]};
        bus_state     = 1'b1;
      end
      S_WR_FRM: begin
        avm_address   = 8'h05;
        avm_writedata = {16'h0, 16'(MAX_FRAME)};
        bus_state     = 1'b1;
      end
      S_WR_ENA: begin
        avm_address   = 8'h02;
        avm_writedata = 32'h0000_0013;
        bus_state     = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are pure decode of async-reset state, so they drop the instant reset asserts.
  assign avm_write = bus_state & ~rd_state & ~gap;
  assign avm_read  = bus_state & rd_state & ~gap;
  assign xfer_ok   = (avm_write | avm_read) & ~avm_waitrequest;
  assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign go        = start || (AUTO_START && first);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= S_IDLE;
      gap         <= 1'b0;
      first       <= 1'b1;
      poll_cnt    <= '0;
      avm_mac_sel <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_mac     <= 1'b0;
    end else begin
      first <= 1'b0;
      gap   <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (go) begin
            state       <= S_WR_RST;
            avm_mac_sel <= 1'b0;
            poll_cnt    <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
          end
        end
        S_RD_POLL: begin
          if (xfer_ok) begin
            if (!avm_readdata[13]) begin
              state <= S_WR_MAC0;
              gap   <= 1'b1;
            end else begin
              if (poll_cnt != POLL_MAX) poll_cnt <= poll_cnt + CW'(1);
              if (poll_cnt + CW'(1) == POLL_MAX) begin
                state   <= S_ERR;
                error   <= 1'b1;
                err_mac <= avm_mac_sel;
              end
            end
          end
        end
        S_WR_RST:  if (xfer_ok) begin state <= S_RD_POLL; gap <= 1'b1; end
        S_WR_MAC0: if (xfer_ok) begin state <= S_WR_MAC1; gap <= 1'b1; end
        S_WR_MAC1: if (xfer_ok) begin state <= S_WR_FRM;  gap <= 1'b1; end
        S_WR_FRM:  if (xfer_ok) begin state <= S_WR_ENA;  gap <= 1'b1; end
        S_WR_ENA: begin
          // For MAC 1 the closing turnaround cycle is the DONE entry itself.
          if (xfer_ok) begin
            if (avm_mac_sel) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (!avm_mac_sel) begin
            avm_mac_sel <= 1'b1;
            poll_cnt    <= '0;
            state       <= S_WR_RST;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tse_init_seq.sv
// tb/tb_tse_init_seq.sv - Self-checking bench for tse_init_seq with a stalling Avalon slave model.
module tb_tse_init_seq;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_mac_sel;
  logic [7:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_waitrequest = 1'b0;
  logic        busy, done, error, err_mac;

  always #5 clk_clk = ~clk_clk;

  tse_init_seq #(.POLL_LIMIT(8)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start),
    .avm_mac_sel(avm_mac_sel), .avm_address(avm_address), .avm_write(avm_write),
    .avm_read(avm_read), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done), .error(error),
    .err_mac(err_mac)
  );

  typedef struct packed {
    logic        sel;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int max_wait;
    int hold0;
    int hold1;
    bit e_done;
    bit e_err;
    bit e_mac;
    int e_rd0;
    int e_rd1;
    int e_nwr;
  } scen_t;

  wr_t   wr_q[$];
  wr_t   exp_wr[10];
  scen_t sc[7];
  int    rd_tot[2];
  int    rd_base[2];
  int    hold[2];
  int    max_wait = 0;
  bit    stall_mac1 = 1'b0;
  int    stall_viol = 0;
  int    both_viol = 0;
  int    checks = 0;
  int    errors = 0;
  int    wbase = 0;
  bit    active = 1'b0;
  int    wcnt = 0;
  logic [42:0] lat;

  // Slave model: decides waitrequest/readdata mid-cycle, logs completed transfers.
  always @(negedge clk_clk) begin
    if (avm_write && avm_read) both_viol++;
    if (avm_write || avm_read) begin
      if (!active) begin
        active = 1'b1;
        wcnt   = int'($urandom_range(max_wait, 0));
        lat    = {avm_mac_sel, avm_write, avm_read, avm_address, avm_writedata};
      end else if (lat != {avm_mac_sel, avm_write, avm_read, avm_address, avm_writedata}) begin
        stall_viol++;
      end
      if (stall_mac1 && avm_mac_sel && avm_write) begin
        avm_waitrequest = 1'b1;
      end else if (wcnt != 0) begin
        avm_waitrequest = 1'b1;
        wcnt--;
      end else begin
        avm_waitrequest = 1'b0;
        active = 1'b0;
        if (avm_write) begin
          wr_q.push_back('{avm_mac_sel, avm_address, avm_writedata});
        end else begin
          avm_readdata = ((rd_tot[avm_mac_sel] - rd_base[avm_mac_sel]) < hold[avm_mac_sel])
                         ? 32'h0000_2000 : 32'h0;
          rd_tot[avm_mac_sel]++;
        end
      end
    end else begin
      active = 1'b0;
      avm_waitrequest = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic mark();
    wbase = wr_q.size();
    rd_base[0] = rd_tot[0];
    rd_base[1] = rd_tot[1];
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!((done || error) && !busy) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected done or error", name, n);
    end
  endtask

  task automatic check_writes(input string name, input int nexp);
    chk($sformatf("%s_nwr", name), 64'(wr_q.size() - wbase), 64'(nexp));
    for (int i = 0; i < nexp && wbase + i < wr_q.size(); i++)
      chk($sformatf("%s_wr%0d", name, i), 64'(wr_q[wbase + i]), 64'(exp_wr[i]));
  endtask

  initial begin
    int n;
    exp_wr[0] = '{1'b0, 8'h02, 32'h0000_2010};
    exp_wr[1] = '{1'b0, 8'h03, 32'h1723_1C00};
    exp_wr[2] = '{1'b0, 8'h04, 32'h0000_CB4A};
    exp_wr[3] = '{1'b0, 8'h05, 32'h0000_05EE};
    exp_wr[4] = '{1'b0, 8'h02, 32'h0000_0013};
    exp_wr[5] = '{1'b1, 8'h02, 32'h0000_2010};
    exp_wr[6] = '{1'b1, 8'h03, 32'h1723_1C00};
    exp_wr[7] = '{1'b1, 8'h04, 32'h0000_CC4A};
    exp_wr[8] = '{1'b1, 8'h05, 32'h0000_05EE};
    exp_wr[9] = '{1'b1, 8'h02, 32'h0000_0013};
    //           wait hold0 hold1 done err mac rd0 rd1 nwr
    sc[0] = '{0, 0,    0,    1, 0, 0, 1, 1, 10};
    sc[1] = '{7, 0,    0,    1, 0, 0, 1, 1, 10};
    sc[2] = '{0, 5,    0,    1, 0, 0, 6, 1, 10};
    sc[3] = '{3, 0,    1000, 0, 1, 1, 1, 8, 6};
    sc[4] = '{0, 1000, 0,    0, 1, 0, 8, 0, 1};
    sc[5] = '{5, 7,    0,    1, 0, 0, 8, 1, 10};
    sc[6] = '{0, 0,    8,    0, 1, 1, 1, 8, 6};
    rd_tot = '{0, 0};
    rd_base = '{0, 0};
    hold = '{0, 0};

    repeat (3) tick();
    chk("reset_outs", 64'({avm_mac_sel, avm_address, avm_write, avm_read, avm_writedata,
                           busy, done, error, err_mac}), 64'h0);

    mark();
    reset_reset_n = 1'b1;
    tick();
    chk("auto_first", 64'({avm_write, avm_read, avm_address, busy, avm_mac_sel}),
        64'({1'b1, 1'b0, 8'h02, 1'b1, 1'b0}));
    wait_end("auto");
    chk("auto_done", 64'({done, error}), 64'b10);
    check_writes("auto", 10);

    mark();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    chk("start_lat", 64'({busy, avm_write, done}), 64'b110);
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("seq_len", 64'(n), 64'd24);
    wait_end("seq_len");

    for (int i = 0; i < 7; i++) begin
      max_wait = sc[i].max_wait;
      hold[0]  = sc[i].hold0;
      hold[1]  = sc[i].hold1;
      mark();
      pulse_start();
      wait_end($sformatf("sc%0d", i));
      chk($sformatf("sc%0d_status", i), 64'({done, error, busy, avm_write, avm_read}),
          64'({sc[i].e_done, sc[i].e_err, 3'b000}));
      if (sc[i].e_err) chk($sformatf("sc%0d_err_mac", i), 64'(err_mac), 64'(sc[i].e_mac));
      chk($sformatf("sc%0d_rd0", i), 64'(rd_tot[0] - rd_base[0]), 64'(sc[i].e_rd0));
      chk($sformatf("sc%0d_rd1", i), 64'(rd_tot[1] - rd_base[1]), 64'(sc[i].e_rd1));
      check_writes($sformatf("sc%0d", i), sc[i].e_nwr);
    end
    hold = '{0, 0};

    max_wait = 2;
    mark();
    pulse_start();
    repeat (15) tick();
    pulse_start();
    wait_end("midstart");
    chk("midstart_done", 64'({done, error}), 64'b10);
    check_writes("midstart", 10);
    mark();
    pulse_start();
    chk("restart_clr", 64'({done, busy}), 64'b01);
    wait_end("restart");
    check_writes("restart", 10);

    max_wait = 0;
    stall_mac1 = 1'b1;
    mark();
    pulse_start();
    n = 0;
    while (!(avm_mac_sel && avm_write) && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("stall_mac1", 64'({avm_mac_sel, avm_write, avm_waitrequest}), 64'b111);
    #2 reset_reset_n = 1'b0;
    #1 chk("rst_async", 64'({avm_write, avm_read, busy, avm_mac_sel}), 64'h0);
    stall_mac1 = 1'b0;
    tick();
    tick();
    mark();
    reset_reset_n = 1'b1;
    tick();
    chk("rst_restart", 64'({avm_write, avm_mac_sel, avm_address}), 64'({1'b1, 1'b0, 8'h02}));
    wait_end("rst_restart");
    check_writes("rst_restart", 10);

    chk("stall_stable", 64'(stall_viol), 64'd0);
    chk("rw_exclusive", 64'(both_viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tse_init_seq.md
# tse_init_seq

Power-up configuration sequencer for the two Triple-Speed Ethernet MACs in the pass-through system. It is an Avalon-MM master on `sys_clk` that brings each MAC out of software reset and programs its station address and maximum frame length. It then enables TX/RX and promiscuous mode, first for MAC 0 and then for MAC 1. It sits inside the pass-through system next to both MACs, and its `done`/`error` status drives LEDs at the top level.

## Interface

Parameters:
- `MAC_ADDR_0`, default 48'h001C_2317_4ACB: station address programmed into MAC 0.
- `MAC_ADDR_1`, default 48'h001C_2317_4ACC: station address programmed into MAC 1.
- `MAX_FRAME`, default 1518: value written to `frm_length`; 16 bits, zero-extended.
- `POLL_LIMIT`, default 1024: maximum number of reset-poll reads per MAC before the block errors.
- `AUTO_START`, default 1: when 1, the sequence starts automatically after reset.

Ports:
- `clk_clk`, in, 1: system clock; all logic is on the rising edge.
- `reset_reset_n`, in, 1: asynchronous reset, active low.
- `start`, in, 1: one-cycle pulse that starts or restarts the sequence.
- `avm_mac_sel`, out, 1: target MAC (0 or 1); it steers the system interconnect.
- `avm_address`, out, 8: register word address within the selected MAC.
- `avm_write`, out, 1: write strobe.
- `avm_read`, out, 1: read strobe.
- `avm_writedata`, out, 32: write data.
- `avm_readdata`, in, 32: read data; valid in the cycle where `avm_read`=1 and `avm_waitrequest`=0.
- `avm_waitrequest`, in, 1: slave stall.
- `busy`, out, 1: high while the sequence is running.
- `done`, out, 1: sticky; high once both MACs are configured.
- `error`, out, 1: sticky; high on a poll timeout.
- `err_mac`, out, 1: index of the MAC that timed out; valid while `error`=1.

## Operation

States:
- IDLE
- WR_RST: address 0x02, data 0x0000_2010 (SW_RESET bit 13, PROMIS_EN bit 4).
- RD_POLL: address 0x02.
- WR_MAC0: address 0x03, data {A[23:16],A[31:24],A[39:32],A[47:40]}.
- WR_MAC1: address 0x04, data {16'h0,A[7:0],A[15:8]}.
- WR_FRM: address 0x05, data MAX_FRAME.
- WR_ENA: address 0x02, data 0x0000_0013 (TX_ENA, RX_ENA, PROMIS_EN).
- NEXT, DONE, ERR.

In these states, A is the station address of the currently selected MAC.

Transitions:
- **Start condition.** IDLE/DONE/ERR → WR_RST when `start`=1, or on the first cycle out of reset when AUTO_START=1. On entry:
  - `avm_mac_sel`=0, poll counter=0.
  - `done` and `error` are cleared.
- **`start` while busy.** Ignored.
- **Bus transfers.** Every write and read state asserts its strobe with stable address and data until the cycle where `avm_waitrequest`=0. The transfer completes in that cycle. The state advances on the next edge.
- **Write order.** WR_RST → RD_POLL; WR_MAC0 → WR_MAC1 → WR_FRM → WR_ENA → NEXT.
- **RD_POLL, reset cleared.** On completion with readdata[13]=0 → WR_MAC0.
- **RD_POLL, reset still set.** On completion with readdata[13]=1, the poll counter increments:
  - If the new count equals POLL_LIMIT → ERR, with `err_mac`=`avm_mac_sel`.
  - Otherwise, stay in RD_POLL; the read is re-issued with no idle cycle.
- **NEXT.** If `avm_mac_sel`=0: set `avm_mac_sel`=1, clear the poll counter, → WR_RST. Otherwise → DONE.
- **DONE.** `done`=1, `busy`=0.
- **ERR.** `error`=1, `busy`=0. The sequence is aborted; MAC 1 is not touched if MAC 0 failed.

General rules:
- `avm_read` and `avm_write` are never high together.
- Both strobes are 0 in IDLE, NEXT, DONE and ERR.
- The poll counter is clog2(POLL_LIMIT+1) bits wide and saturates; it never wraps.

## Timing

- **Reset values.** All outputs are 0: strobes, `avm_address`, `avm_writedata`, `avm_mac_sel`, `busy`, `done`, `error`, `err_mac`. The state is IDLE.
- **Reset mid-transfer.** The strobes drop asynchronously. After reset is released, AUTO_START restarts the sequence from MAC 0.
- **Start latency.**
  - A `start` pulse in cycle N gives `busy`=1 and `avm_write`=1 (WR_RST) in cycle N+1.
  - With AUTO_START, the first write is asserted in the first edge after `reset_reset_n` rises.
- **Per-transfer cost.** Each transfer costs (waitrequest cycles + 1) cycles in its state, plus 1 cycle of state turnaround.
- **Minimum sequence length.** With zero wait states and the reset bit clearing on the first poll, the full sequence is 24 cycles from `start` to `done`=1:
  - 6 transfers × 2 cycles × 2 MACs,
  - plus NEXT,
  - absorbed into DONE entry.

## Test plan

- **Zero-wait, AUTO_START=1, default addresses.** Expect writes to MAC 0 at 0x02=0x2010, 0x03=0x17231C00, 0x04=0x0000CB4A, 0x05=0x05EE, 0x02=0x13. The same five writes follow to MAC 1, with 0x04=0x0000CC4A. `done`=1 and `error`=0.
- **Random waitrequest stalls of 0–7 cycles.** Address and data stay stable throughout every stall. No transfer is duplicated or dropped. The final write set is identical to the zero-wait case.
- **MAC 0 reset bit held for 5 reads, then cleared.** Exactly 6 reads of 0x02 occur, then the sequence continues normally to `done`=1.
- **MAC 1 reset bit stuck, POLL_LIMIT=8.** Exactly 8 reads to MAC 1, then `error`=1, `err_mac`=1, `done`=0, strobes 0, `busy`=0.
- **`start` pulsed mid-sequence, then `start` after DONE.** The mid-sequence pulse has no effect. The post-DONE pulse clears `done` and replays the full 10-write sequence.
- **`reset_reset_n` asserted during a stalled write to MAC 1.** Strobes drop immediately. After release, the sequence restarts at MAC 0, address 0x02.
